// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I instruction fetch stage and IF/ID pipeline register.
//            Issues one-outstanding req/gnt/rvalid fetches and parks a
//            response that arrives during a load-use stall. A branch or jump
//            redirect flushes the IF/ID register and drops any fetch that is
//            still in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  // Source selected for the IF/ID register when a real instruction lands.
  logic        load_w;
  logic [31:0] load_instr_w;
  logic [31:0] load_pc_w;

  // Next-state logic: fetch FSM, PC, skid buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    load_w       = 1'b0;
    load_instr_w = imem_rdata_i;
    load_pc_w    = req_pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          // A redirect in the grant cycle means the fetch just issued is stale.
          kill_d   = redirect_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_i) begin
            if (stall_i) begin
              // Decode cannot take it yet: park the word until the stall lifts.
              buf_instr_d = imem_rdata_i;
              buf_pc_d    = req_pc_q;
              buf_valid_d = 1'b1;
              state_d     = S_HOLD;
            end else begin
              load_w = 1'b1;
            end
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d     = S_REQ;
          buf_valid_d = 1'b0;
        end else if (!stall_i) begin
          load_w       = buf_valid_q;
          load_instr_w = buf_instr_q;
          load_pc_w    = buf_pc_q;
          buf_valid_d  = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_i) begin
      pc_d        = {redirect_pc_i[31:2], 2'b00};
      buf_valid_d = 1'b0;
    end

    // IF/ID: redirect bubble beats stall hold, which beats a fresh load.
    if (redirect_i) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (load_w) begin
        id_instr_d = load_instr_w;
        id_pc_d    = load_pc_w;
        id_valid_d = 1'b1;
      end else begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      kill_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0000_0000;
      buf_valid_q <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= 32'h0000_0000;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign id_valid_o  = id_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] C_NOP       = 32'h0000_0013;
  localparam int          C_RAND_CYC  = 3000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;

  fetch_stage #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_valid_o    (id_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a fetch pointer, an in-flight transaction record and a
  // queue of responses waiting for decode to accept them.
  logic        m_idle;
  logic [31:0] m_pc;
  logic        m_out;
  logic [31:0] m_out_pc;
  logic        m_dead;
  logic [63:0] m_held[$];
  logic [31:0] m_id_instr;
  logic [31:0] m_id_pc;
  logic        m_id_valid;
  int          m_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic exp_req();
    return !m_idle && !m_out && (m_held.size() == 0);
  endfunction

  task automatic model_reset();
    m_idle     = 1'b1;
    m_pc       = C_RESET_PC;
    m_out      = 1'b0;
    m_out_pc   = 32'h0;
    m_dead     = 1'b0;
    m_held.delete();
    m_id_instr = C_NOP;
    m_id_pc    = 32'h0;
    m_id_valid = 1'b0;
    m_lat      = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic        have;
    logic [31:0] gi, gp;
    logic [63:0] e;
    have = 1'b0;
    gi   = 32'h0;
    gp   = 32'h0;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_held.size() != 0) begin
      if (redirect_i) m_held.delete();
      else if (!stall_i) begin
        e    = m_held.pop_front();
        gi   = e[63:32];
        gp   = e[31:0];
        have = 1'b1;
      end
    end else if (m_out) begin
      if (imem_rvalid_i) begin
        m_out = 1'b0;
        if (!m_dead && !redirect_i) begin
          if (stall_i) m_held.push_back({imem_rdata_i, m_out_pc});
          else begin
            gi   = imem_rdata_i;
            gp   = m_out_pc;
            have = 1'b1;
          end
        end
      end else if (redirect_i) begin
        m_dead = 1'b1;
      end
    end else if (imem_gnt_i) begin
      m_out    = 1'b1;
      m_out_pc = m_pc;
      m_dead   = redirect_i;
      m_pc     = m_pc + 32'd4;
      m_lat    = $urandom_range(2, 0);
    end
    if (redirect_i) m_pc = redirect_pc_i & 32'hFFFF_FFFC;

    if (redirect_i) begin
      m_id_instr = C_NOP;
      m_id_valid = 1'b0;
    end else if (!stall_i) begin
      if (have) begin
        m_id_instr = gi;
        m_id_pc    = gp;
        m_id_valid = 1'b1;
      end else begin
        m_id_instr = C_NOP;
        m_id_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("req",      {31'h0, imem_req_o}, {31'h0, exp_req()});
    check("addr",     imem_addr_o, m_pc);
    check("id_instr", id_instr_o,  m_id_instr);
    check("id_pc",    id_pc_o,     m_id_pc);
    check("id_valid", {31'h0, id_valid_o}, {31'h0, m_id_valid});
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rd);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic rand_step();
    logic        s, r, g, rv;
    logic [31:0] rpc;
    s   = ($urandom_range(3, 0) == 0);
    r   = ($urandom_range(9, 0) == 0);
    rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
    g   = exp_req() ? ($urandom_range(2, 0) != 0) : 1'b0;
    if (m_out) begin
      if (m_lat == 0) rv = 1'b1;
      else begin
        rv = 1'b0;
        m_lat--;
      end
    end else begin
      rv = ($urandom_range(7, 0) == 0);
    end
    drive(s, r, rpc, g, rv, $urandom);
    cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();

    // Reset state.
    @(negedge clk_i);
    check("rst_req",   {31'h0, imem_req_o}, 32'h0);
    check("rst_addr",  imem_addr_o, C_RESET_PC);
    check("rst_instr", id_instr_o, C_NOP);
    check("rst_pc",    id_pc_o, 32'h0);
    check("rst_valid", {31'h0, id_valid_o}, 32'h0);
    rst_ni = 1'b1;
    cycle();
    check("t1_req", {31'h0, imem_req_o}, 32'h1);
    check("t1_addr", imem_addr_o, 32'h0);

    // 1: immediate grant, response one cycle later.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093);
    cycle();
    check("t1_instr", id_instr_o, 32'h0050_0093);
    check("t1_pc",    id_pc_o, 32'h0);
    check("t1_valid", {31'h0, id_valid_o}, 32'h1);
    check("t1_next",  imem_addr_o, 32'h4);

    // 2: stall across the response, three cycles.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0113);
    cycle();
    check("t2_req0", {31'h0, imem_req_o}, 32'h0);
    check("t2_hold", id_instr_o, C_NOP);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    check("t2_req2", {31'h0, imem_req_o}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    check("t2_instr", id_instr_o, 32'h00A0_0113);
    check("t2_pc",    id_pc_o, 32'h4);
    check("t2_valid", {31'h0, id_valid_o}, 32'h1);

    // 3: redirect while waiting, late response must be dropped.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cycle();
    check("t3_instr", id_instr_o, C_NOP);
    check("t3_valid", {31'h0, id_valid_o}, 32'h0);
    check("t3_addr",  imem_addr_o, 32'h100);
    check("t3_req",   {31'h0, imem_req_o}, 32'h1);

    // 4: redirect together with stall.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093);
    cycle();
    check("t4_pre", {31'h0, id_valid_o}, 32'h1);
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    cycle();
    check("t4_valid", {31'h0, id_valid_o}, 32'h0);
    check("t4_addr",  imem_addr_o, 32'h200);

    // 5: unaligned target near the top of the address space wraps.
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    cycle();
    check("t5_addr", imem_addr_o, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    cycle();
    check("t5_pc",   id_pc_o, 32'hFFFF_FFFC);
    check("t5_wrap", imem_addr_o, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < C_RAND_CYC; i++) rand_step();

    // 6: asynchronous reset while a fetch is outstanding.
    for (int i = 0; i < 20 && !m_out; i++) begin
      drive(1'b0, 1'b0, 32'h0, exp_req(), 1'b0, 32'h0);
      cycle();
    end
    check("t6_in_wait", {31'h0, m_out}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_req",   {31'h0, imem_req_o}, 32'h0);
    check("t6_addr",  imem_addr_o, C_RESET_PC);
    check("t6_instr", id_instr_o, C_NOP);
    check("t6_pc",    id_pc_o, 32'h0);
    check("t6_valid", {31'h0, id_valid_o}, 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    cycle();
    check("t6_stale_req",   {31'h0, imem_req_o}, 32'h1);
    check("t6_stale_valid", {31'h0, id_valid_o}, 32'h0);
    cycle();
    check("t6_first_addr", imem_addr_o, C_RESET_PC);
    check("t6_first_inst", id_instr_o, C_NOP);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093);
    cycle();
    check("t6_instr",  id_instr_o, 32'h0050_0093);
    check("t6_pc_out", id_pc_o, C_RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
